// File: rtl/kbd_pkg.sv
// kbd_display shared definitions: scan-code constants,
// seven-segment font and set-2 to ASCII translation.
package kbd_pkg;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Active-low a..g,dp; entry n is the glyph for hex digit n.
    localparam logic [15:0][7:0] HEX_FONT = {
        8'h71, 8'h61, 8'h85, 8'h63,
        8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99,
        8'h0D, 8'h25, 8'h9F, 8'h03
    };

    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        return HEX_FONT[nib];
    endfunction

    function automatic logic [7:0] set2_ascii(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h61;
            8'h32: a = 8'h62;
            8'h21: a = 8'h63;
            8'h23: a = 8'h64;
            8'h24: a = 8'h65;
            8'h2B: a = 8'h66;
            8'h34: a = 8'h67;
            8'h33: a = 8'h68;
            8'h43: a = 8'h69;
            8'h3B: a = 8'h6A;
            8'h42: a = 8'h6B;
            8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;
            8'h31: a = 8'h6E;
            8'h44: a = 8'h6F;
            8'h4D: a = 8'h70;
            8'h15: a = 8'h71;
            8'h2D: a = 8'h72;
            8'h1B: a = 8'h73;
            8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;
            8'h2A: a = 8'h76;
            8'h1D: a = 8'h77;
            8'h22: a = 8'h78;
            8'h35: a = 8'h79;
            8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;
            8'h16: a = 8'h31;
            8'h1E: a = 8'h32;
            8'h26: a = 8'h33;
            8'h25: a = 8'h34;
            8'h2E: a = 8'h35;
            8'h36: a = 8'h36;
            8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/kbd_display_ps2_rx.sv
// PS/2 frame receiver: synchronises ps2_clk, shifts in eleven
// bits per frame and emits a one-cycle pulse for good frames.
module ps2_rx
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code_o,
    output logic       code_valid_o
);

    logic [2:0]  sync_q;
    logic [10:0] shift_q;
    logic [10:0] shift_d;
    logic [3:0]  bit_cnt_q;
    logic        done_q;
    logic        valid_q;
    logic [7:0]  code_q;
    logic        fall;
    logic        frame_ok;

    assign fall    = (sync_q[2:1] == 2'b10);
    assign shift_d = {ps2_data_i, shift_q[10:1]};

    // shift_q[0]=start, [8:1]=data, [9]=parity, [10]=stop
    assign frame_ok = !shift_q[0] && shift_q[10] && (^shift_q[9:1]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= 3'b111;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= '0;
        end else begin
            sync_q  <= {sync_q[1:0], ps2_clk_i};
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            if (fall) begin
                shift_q <= shift_d;
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= '0;
                    done_q    <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end
            if (done_q) begin
                valid_q <= frame_ok;
                code_q  <= shift_q[8:1];
            end
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = valid_q;

endmodule

// File: rtl/kbd_display.sv
// Board I/O front-end: PS/2 key tracking, press counter,
// eight seven-segment digits and LED mapping.
module kbd_display
    import kbd_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    output logic [15:0] ledr,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [7:0]  seg5,
    output logic [7:0]  seg6,
    output logic [7:0]  seg7
);

    logic [7:0] code;
    logic       code_valid;

    logic       break_q;
    logic       key_down_q;
    logic [7:0] cur_code_q;
    logic [7:0] count_q;
    logic [7:0] ascii;
    logic       ascii_on;

    ps2_rx u_rx (
        .clk          (clk),
        .resetn       (resetn),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .code_o       (code),
        .code_valid_o (code_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            break_q    <= 1'b0;
            key_down_q <= 1'b0;
            cur_code_q <= '0;
            count_q    <= '0;
        end else if (code_valid) begin
            if (code == CODE_BREAK) begin
                break_q <= 1'b1;
            end else if (code == CODE_EXT) begin
                break_q <= break_q;
            end else if (break_q) begin
                break_q    <= 1'b0;
                key_down_q <= 1'b0;
            end else if (!(key_down_q && code == cur_code_q)) begin
                // typematic repeats of the held key fall through untouched
                cur_code_q <= code;
                key_down_q <= 1'b1;
                count_q    <= count_q + 8'd1;
            end
        end
    end

    assign ascii    = set2_ascii(cur_code_q);
    assign ascii_on = key_down_q && (ascii != 8'h00);

    assign seg0 = key_down_q ? hex_seg(cur_code_q[3:0]) : SEG_BLANK;
    assign seg1 = key_down_q ? hex_seg(cur_code_q[7:4]) : SEG_BLANK;
    assign seg2 = ascii_on ? hex_seg(ascii[3:0]) : SEG_BLANK;
    assign seg3 = ascii_on ? hex_seg(ascii[7:4]) : SEG_BLANK;
    assign seg4 = hex_seg(count_q[3:0]);
    assign seg5 = hex_seg(count_q[7:4]);
    assign seg6 = hex_seg(sw[3:0]);
    assign seg7 = hex_seg(sw[7:4]);

    assign ledr = {key_down_q, 2'b00, btn, sw};

endmodule

// File: tb/tb_kbd_display.sv
// Directed self-checking bench for kbd_display: PS/2 frames in,
// seven-segment and LED values compared against hand-computed tables.
module tb_kbd_display;

    localparam int HALF = 5;
    localparam int GAP  = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [4:0]  btn = '0;
    logic [7:0]  sw = 8'h5A;
    logic [15:0] ledr;
    logic [7:0]  seg0, seg1, seg2, seg3;
    logic [7:0]  seg4, seg5, seg6, seg7;

    int n_checks = 0;
    int n_errors = 0;

    kbd_display dut (
        .clk      (clk),
        .resetn   (resetn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .btn      (btn),
        .sw       (sw),
        .ledr     (ledr),
        .seg0     (seg0),
        .seg1     (seg1),
        .seg2     (seg2),
        .seg3     (seg3),
        .seg4     (seg4),
        .seg5     (seg5),
        .seg6     (seg6),
        .seg7     (seg7)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] code, input logic bad);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad, code, 1'b0};
        send_bits(f, 11);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic check_all(input string tag,
                             input logic [31:0] lo,
                             input logic [31:0] hi,
                             input logic [15:0] led);
        @(negedge clk);
        check({tag, ".lo"}, {seg3, seg2, seg1, seg0}, lo);
        check({tag, ".hi"}, {seg7, seg6, seg5, seg4}, hi);
        check({tag, ".led"}, {16'h0, ledr}, {16'h0, led});
    endtask

    initial begin
        logic [10:0] part;
        repeat (3) @(negedge clk);
        check_all("reset", 32'hFFFFFFFF, 32'h49110303, 16'h005A);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_all("post_reset", 32'hFFFFFFFF, 32'h49110303, 16'h005A);

        send(8'h1C, 1'b0);
        check_all("make_1c", 32'h419F9F63, 32'h4911039F, 16'h805A);

        send(8'h1C, 1'b0);
        send(8'h1C, 1'b0);
        send(8'h1C, 1'b0);
        check_all("repeat", 32'h419F9F63, 32'h4911039F, 16'h805A);

        send(8'hF0, 1'b0);
        check_all("f0_only", 32'h419F9F63, 32'h4911039F, 16'h805A);
        send(8'h1C, 1'b0);
        check_all("break", 32'hFFFFFFFF, 32'h4911039F, 16'h005A);

        send(8'h1C, 1'b0);
        check_all("repress", 32'h419F9F63, 32'h49110325, 16'h805A);

        send(8'hE0, 1'b0);
        check_all("e0", 32'h419F9F63, 32'h49110325, 16'h805A);

        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        send(8'h1C, 1'b1);
        check_all("bad_par", 32'hFFFFFFFF, 32'h49110325, 16'h005A);
        send(8'h45, 1'b0);
        check_all("good_45", 32'h0D039949, 32'h4911030D, 16'h805A);

        btn = 5'h15;
        sw  = 8'h3C;
        check_all("sw_btn", 32'h0D039949, 32'h0D63030D, 16'h953C);
        btn = '0;
        sw  = 8'h5A;

        part = {1'b1, 1'b0, 8'h1C, 1'b0};
        send_bits(part, 5);
        @(negedge clk);
        resetn = 1'b0;
        check_all("mid_rst", 32'hFFFFFFFF, 32'h49110303, 16'h005A);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h16, 1'b0);
        check_all("after_rst", 32'h0D9F9F41, 32'h4911039F, 16'h805A);

        for (int i = 0; i < 255; i++)
            send((i % 2 == 0) ? 8'h1C : 8'h32, 1'b0);
        check_all("wrap", 32'h419F9F63, 32'h49110303, 16'h805A);

        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        send(8'h05, 1'b0);
        check_all("unmapped", 32'hFFFF0349, 32'h4911039F, 16'h805A);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
